// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx_si, samples each bit at mid-bit and
// presents the received word with ready / framing-or-overrun error status.
module uart_rx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 rx_si,
  input  logic                 rx_data_ack,
  output logic [DATA_BITS-1:0] rx_po,
  output logic                 rx_busy,
  output logic                 rx_ready,
  output logic                 rx_error
);

  // state | meaning
  // IDLE  | line idle, waiting for a falling edge on the synchronised input
  // START | half-bit wait, then confirm the start bit is still low
  // DATA  | sampling data bits at mid-bit, LSB first
  // STOP  | sampling the stop bit and publishing word/status
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam int TMR_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] FULL_LOAD = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  state_t               state;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s_meta;
  logic                 s;
  logic                 s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      s_meta <= rx_si;
      s      <= s_meta;
      s_prev <= s;
    end
  end

  // Timer is a down-counter; each state acts when it reaches terminal count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_po    <= '0;
      rx_busy  <= 1'b0;
      rx_ready <= 1'b0;
      rx_error <= 1'b0;
    end else begin
      if (rx_data_ack) begin
        rx_ready <= 1'b0;
        rx_error <= 1'b0;
      end
      if (!en && state != IDLE) begin
        state   <= IDLE;
        rx_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (en && s_prev && !s) begin
              state   <= START;
              timer   <= HALF_LOAD;
              bit_idx <= '0;
              rx_busy <= 1'b1;
            end
          end
          START: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else if (s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
              timer <= FULL_LOAD;
            end
          end
          DATA: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              shreg[bit_idx] <= s;
              timer          <= FULL_LOAD;
              if (bit_idx == LAST_IDX) state <= STOP;
              else bit_idx <= bit_idx + 1'b1;
            end
          end
          STOP: begin
            if (timer != '0) begin
              timer <= timer - 1'b1;
            end else begin
              state   <= IDLE;
              rx_busy <= 1'b0;
              rx_po   <= shreg;
              // Publishing outranks a same-cycle acknowledge.
              if (s) begin
                rx_ready <= 1'b1;
                if (rx_ready) rx_error <= 1'b1;
              end else begin
                rx_error <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 8 clocks per bit: frames, glitch, overrun,
// enable abort and asynchronous reset.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       rx_si;
  logic       rx_data_ack;
  logic [7:0] rx_po;
  logic       rx_busy;
  logic       rx_ready;
  logic       rx_error;

  int total = 0;
  int bad   = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rx_si       (rx_si),
    .rx_data_ack (rx_data_ack),
    .rx_po       (rx_po),
    .rx_busy     (rx_busy),
    .rx_ready    (rx_ready),
    .rx_error    (rx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input logic stop_b, input int k);
    int idx;
    idx = k / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return stop_b;
    return 1'b1;
  endfunction

  // Drive the line for frame cycles [from, to); cycle 0 starts at the start-bit edge.
  task automatic frame_seg(input logic [7:0] d, input logic stop_b, input int from, input int to);
    for (int k = from; k < to; k++) begin
      rx_si = frame_bit(d, stop_b, k);
      step(1);
    end
    rx_si = frame_bit(d, stop_b, to);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] po, input logic busy,
                         input logic rdy, input logic err);
    chk({tag, "_po"},    {24'h0, rx_po}, {24'h0, po});
    chk({tag, "_busy"},  {31'h0, rx_busy}, {31'h0, busy});
    chk({tag, "_ready"}, {31'h0, rx_ready}, {31'h0, rdy});
    chk({tag, "_error"}, {31'h0, rx_error}, {31'h0, err});
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; rx_si = 1'b1; rx_data_ack = 1'b0;
    step(3);
    chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; en = 1'b1;
    step(20);
    chk_all("idle", 8'h00, 1'b0, 1'b0, 1'b0);

    // 0x55 with exact output latency
    frame_seg(8'h55, 1'b1, 0, 4);
    chk("f55_busy_rise", {31'h0, rx_busy}, 32'h1);
    frame_seg(8'h55, 1'b1, 4, 78);
    chk("f55_busy_mid", {31'h0, rx_busy}, 32'h1);
    chk("f55_ready_early", {31'h0, rx_ready}, 32'h0);
    frame_seg(8'h55, 1'b1, 78, 79);
    chk_all("f55_done", 8'h55, 1'b0, 1'b1, 1'b0);
    frame_seg(8'h55, 1'b1, 79, 90);
    rx_data_ack = 1'b1;
    step(2);
    rx_data_ack = 1'b0;
    step(1);
    chk_all("f55_ack", 8'h55, 1'b0, 1'b0, 1'b0);

    // framing error
    frame_seg(8'hD5, 1'b0, 0, 80);
    chk_all("fD5_ferr", 8'hD5, 1'b0, 1'b0, 1'b1);
    frame_seg(8'hD5, 1'b0, 80, 90);
    rx_data_ack = 1'b1;
    step(1);
    rx_data_ack = 1'b0;
    chk_all("fD5_ack", 8'hD5, 1'b0, 1'b0, 1'b0);

    // 2-cycle glitch: busy edges 3..7 only
    rx_si = 1'b0;
    step(2);
    rx_si = 1'b1;
    step(1);
    chk("glitch_busy_on", {31'h0, rx_busy}, 32'h1);
    step(3);
    chk("glitch_busy_hold", {31'h0, rx_busy}, 32'h1);
    step(1);
    chk_all("glitch_done", 8'hD5, 1'b0, 1'b0, 1'b0);
    step(10);

    // back-to-back frames without ack -> overrun
    frame_seg(8'h55, 1'b1, 0, 80);
    chk_all("b2b_first", 8'h55, 1'b0, 1'b1, 1'b0);
    frame_seg(8'hA3, 1'b1, 0, 80);
    chk_all("b2b_overrun", 8'hA3, 1'b0, 1'b1, 1'b1);
    frame_seg(8'hA3, 1'b1, 80, 90);
    rx_data_ack = 1'b1;
    step(1);
    rx_data_ack = 1'b0;
    chk_all("b2b_ack", 8'hA3, 1'b0, 1'b0, 1'b0);

    frame_seg(8'h3C, 1'b1, 0, 90);
    chk_all("f3C", 8'h3C, 1'b0, 1'b1, 1'b0);

    // enable dropped mid-frame, then a full frame while disabled
    frame_seg(8'h81, 1'b1, 0, 40);
    chk("en_busy_before", {31'h0, rx_busy}, 32'h1);
    en = 1'b0;
    step(1);
    chk_all("en_abort", 8'h3C, 1'b0, 1'b1, 1'b0);
    frame_seg(8'h81, 1'b1, 41, 90);
    frame_seg(8'h81, 1'b1, 0, 40);
    chk("en_off_busy", {31'h0, rx_busy}, 32'h0);
    frame_seg(8'h81, 1'b1, 40, 90);
    chk_all("en_off_done", 8'h3C, 1'b0, 1'b1, 1'b0);
    en = 1'b1;
    step(5);

    // asynchronous reset mid-frame
    frame_seg(8'h81, 1'b1, 0, 40);
    chk("rst_busy_before", {31'h0, rx_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 8'h00, 1'b0, 1'b0, 1'b0);
    rx_si = 1'b1;
    step(5);
    rst_n = 1'b1;
    step(20);
    chk_all("rst_idle", 8'h00, 1'b0, 1'b0, 1'b0);

    frame_seg(8'h81, 1'b1, 0, 90);
    chk_all("f81_recover", 8'h81, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
